// File: rtl/tx_frame_sequencer.sv
// Transmit frame sequencer: preamble, SIGNAL word, SERVICE, payload and tail
// nibbles toward the TX chain, with request accept/reject and abort handling.
module tx_frame_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_req,
   input  logic [3:0]  tx_rate,
   input  logic [11:0] tx_length,
   input  logic        tx_abort,
   input  logic [3:0]  pay_data,
   input  logic        pay_valid,
   output logic        pay_ready,
   output logic [3:0]  sym_data,
   output logic        sym_valid,
   input  logic        sym_ready,
   output logic [1:0]  sym_phase,
   output logic        scr_init,
   output logic        scr_en,
   output logic        tx_busy,
   output logic        tx_ack,
   output logic        tx_err,
   output logic        tx_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_SIGNAL, S_SERVICE, S_PAYLOAD, S_TAIL
   } state_e;

   state_e      state_q, state_d;
   logic [12:0] cnt_q, cnt_d;
   logic [3:0]  rate_q, rate_d;
   logic [11:0] len_q, len_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        done_q, done_d;
   logic        init_q, init_d;

   logic [23:0] sig_word;
   logic [3:0]  sig_nib;
   logic [12:0] pay_last;
   logic        xfer;

   function automatic logic [3:0] preamble_nibble(input logic [3:0] i);
      case (i)
         4'd0:    return 4'h1;
         4'd1:    return 4'hD;
         4'd2:    return 4'h5;
         4'd3:    return 4'hB;
         4'd4:    return 4'h3;
         4'd5:    return 4'hE;
         4'd6:    return 4'h6;
         4'd7:    return 4'h8;
         default: return 4'h0;
      endcase
   endfunction

   // Output decode; PAYLOAD is a straight pass-through of the data source.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
      sym_data  = 4'h0;
      sym_valid = 1'b0;
      pay_ready = 1'b0;
      sym_phase = 2'd3;
      scr_en    = 1'b0;
      sig_word  = {6'b0, ^{len_q, rate_q}, len_q, 1'b0, rate_q};
      case (cnt_q[2:0])
         3'd0:    sig_nib = sig_word[3:0];
         3'd1:    sig_nib = sig_word[7:4];
         3'd2:    sig_nib = sig_word[11:8];
         3'd3:    sig_nib = sig_word[15:12];
         3'd4:    sig_nib = sig_word[19:16];
         default: sig_nib = sig_word[23:20];
      endcase
      case (state_q)
         S_PREAMBLE: begin
            sym_valid = 1'b1;
            sym_data  = preamble_nibble(cnt_q[3:0]);
            sym_phase = 2'd0;
         end
         S_SIGNAL: begin
            sym_valid = 1'b1;
            sym_data  = sig_nib;
            sym_phase = 2'd1;
         end
         S_SERVICE: begin
            sym_valid = 1'b1;
            sym_phase = 2'd2;
            scr_en    = 1'b1;
         end
         S_PAYLOAD: begin
            sym_valid = pay_valid;
            sym_data  = pay_data;
            pay_ready = sym_ready & ~tx_abort;
            sym_phase = 2'd2;
            scr_en    = 1'b1;
         end
         S_TAIL: begin
            sym_valid = 1'b1;
            sym_phase = 2'd2;
         end
         default: ;
      endcase
   end

   assign xfer     = sym_valid & sym_ready;
   assign pay_last = {len_q, 1'b0} - 13'd1;
   assign tx_busy  = (state_q != S_IDLE);
   assign tx_ack   = ack_q;
   assign tx_err   = err_q;
   assign tx_done  = done_q;
   assign scr_init = init_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rate_d  = rate_q;
      len_d   = len_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      done_d  = 1'b0;
      init_d  = 1'b0;
      // Abort wins over any transfer on the same cycle.
      if (state_q != S_IDLE && tx_abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: if (tx_req) begin
               if (tx_length != 12'd0 && tx_rate[0]) begin
                  state_d = S_PREAMBLE;
                  rate_d  = tx_rate;
                  len_d   = tx_length;
                  cnt_d   = '0;
                  ack_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            S_PREAMBLE: if (xfer) begin
               cnt_d = cnt_q + 13'd1;
               if (cnt_q == 13'd11) begin
                  state_d = S_SIGNAL;
                  cnt_d   = '0;
               end
            end
            S_SIGNAL: if (xfer) begin
               cnt_d = cnt_q + 13'd1;
               if (cnt_q == 13'd5) begin
                  state_d = S_SERVICE;
                  cnt_d   = '0;
                  init_d  = 1'b1;
               end
            end
            S_SERVICE: if (xfer) begin
               cnt_d = cnt_q + 13'd1;
               if (cnt_q == 13'd3) begin
                  state_d = S_PAYLOAD;
                  cnt_d   = '0;
               end
            end
            S_PAYLOAD: if (xfer) begin
               cnt_d = cnt_q + 13'd1;
               if (cnt_q == pay_last) begin
                  state_d = S_TAIL;
                  cnt_d   = '0;
               end
            end
            S_TAIL: if (xfer) begin
               cnt_d = cnt_q + 13'd1;
               if (cnt_q == 13'd1) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rate_q  <= '0;
         len_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rate_q  <= rate_d;
         len_q   <= len_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         done_q  <= done_d;
         init_q  <= init_d;
      end
   end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Randomized bench for tx_frame_sequencer: a nibble-list frame model with a
// transfer scoreboard, stall stability, reject, abort and reset scenarios.
module tb_tx_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tx_req = 1'b0;
   logic [3:0]  tx_rate = 4'h0;
   logic [11:0] tx_length = 12'h0;
   logic        tx_abort = 1'b0;
   logic [3:0]  pay_data = 4'h0;
   logic        pay_valid = 1'b0;
   logic        sym_ready = 1'b0;
   logic        pay_ready, sym_valid, scr_init, scr_en;
   logic        tx_busy, tx_ack, tx_err, tx_done;
   logic [3:0]  sym_data;
   logic [1:0]  sym_phase;

   int n_vec = 0;
   int n_err = 0;
   int pre[12] = '{1, 13, 5, 11, 3, 14, 6, 8, 0, 0, 0, 0};

   always #5 clk = ~clk;

   tx_frame_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tx_req    (tx_req),
      .tx_rate   (tx_rate),
      .tx_length (tx_length),
      .tx_abort  (tx_abort),
      .pay_data  (pay_data),
      .pay_valid (pay_valid),
      .pay_ready (pay_ready),
      .sym_data  (sym_data),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_phase (sym_phase),
      .scr_init  (scr_init),
      .scr_en    (scr_en),
      .tx_busy   (tx_busy),
      .tx_ack    (tx_ack),
      .tx_err    (tx_err),
      .tx_done   (tx_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_sym_valid"}, sym_valid, 0);
      check({tag, "_pay_ready"}, pay_ready, 0);
      check({tag, "_scr_init"},  scr_init, 0);
      check({tag, "_scr_en"},    scr_en, 0);
      check({tag, "_busy"},      tx_busy, 0);
      check({tag, "_ack"},       tx_ack, 0);
      check({tag, "_err"},       tx_err, 0);
      check({tag, "_done"},      tx_done, 0);
      check({tag, "_sym_data"},  sym_data, 0);
      check({tag, "_phase"},     sym_phase, 3);
   endtask

   // Runs one frame against the model. abort_at: payload nibble index at which
   // to abort (-1 none); rst_at: transfer index at which to reset (-1 none).
   task automatic run_frame(input logic [3:0] rate, input int len, input int stall,
                            input int abort_at, input int rst_at);
      int exp_q[$];
      int src_q[$];
      int total, idx, sp, prev_idx, budget, par, s_word;
      logic hold, pv_hold, expect_done, finished, abort_now, rst_now, in_pay;
      logic [3:0] held;

      par = 0;
      for (int b = 0; b < 4; b++)  par ^= (rate >> b) & 1;
      for (int b = 0; b < 12; b++) par ^= (len >> b) & 1;
      s_word = rate + (len << 5) + (par << 17);
      for (int i = 0; i < 12; i++) exp_q.push_back(pre[i]);
      for (int k = 0; k < 6; k++) exp_q.push_back((s_word >> (4 * k)) & 15);
      repeat (4) exp_q.push_back(0);
      for (int i = 0; i < len; i++) begin
         int byte_v;
         byte_v = int'($urandom_range(255));
         src_q.push_back(byte_v & 15);
         src_q.push_back(byte_v >> 4);
      end
      foreach (src_q[i]) exp_q.push_back(src_q[i]);
      exp_q.push_back(0);
      exp_q.push_back(0);
      total = exp_q.size();

      @(posedge clk); #1;
      tx_req = 1'b1; tx_rate = rate; tx_length = 12'(len);
      @(posedge clk); #1;
      tx_req    = 1'b0;
      sym_ready = (stall == 0) ? 1'b1 : ($urandom_range(99) >= stall);
      pay_valid = (stall == 0) ? 1'b1 : ($urandom_range(99) >= stall);
      pay_data  = 4'(src_q[0]);

      idx = 0; sp = 0; prev_idx = -1; hold = 0; held = 0;
      expect_done = 0; finished = 0; abort_now = 0; rst_now = 0;
      budget = 30 * total + 100;
      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         @(negedge clk);
         if (abort_now) begin
            check("abort_phase", sym_phase, 2);
            @(posedge clk); #1;
            tx_abort = 1'b0; pay_valid = 1'b0;
            @(negedge clk);
            check_idle("after_abort");
            repeat (4) begin
               @(negedge clk);
               check("abort_no_done", tx_done, 0);
            end
            return;
         end
         if (rst_now) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_idle("in_reset");
            @(posedge clk); #1;
            rst_n = 1'b1; sym_ready = 1'b0; pay_valid = 1'b0;
            @(negedge clk);
            check("post_reset_done", tx_done, 0);
            return;
         end
         if (expect_done) begin
            check("tx_done", tx_done, 1);
            check("done_busy", tx_busy, 0);
            check("done_phase", sym_phase, 3);
            check("done_valid", sym_valid, 0);
            finished = 1;
         end else if (tx_done) begin
            check("done_early", idx, total);
            finished = 1;
         end else begin
            check("ack", tx_ack, (cyc == 0));
            check("err_in_frame", tx_err, 0);
            check("busy", tx_busy, 1);
            check("scr_init", scr_init, (idx == 18 && prev_idx == 17));
            in_pay = (idx >= 22) && (idx < 22 + 2 * len);
            if (in_pay) begin
               check("pay_valid_thru", sym_valid, pay_valid);
               check("pay_ready_thru", pay_ready, sym_ready);
            end else begin
               check("sym_valid", sym_valid, 1);
               check("pay_ready_0", pay_ready, 0);
            end
            if (hold) check("stable", sym_data, held);
            hold = sym_valid && !sym_ready;
            held = sym_data;
            prev_idx = idx;
            if (sym_valid && sym_ready) begin
               check("data", sym_data, exp_q[idx]);
               check("phase", sym_phase, (idx < 12) ? 0 : (idx < 18) ? 1 : 2);
               check("scr_en", scr_en, (idx >= 18 && idx < 22 + 2 * len));
               idx++;
               if (idx == total) expect_done = 1;
            end
            pv_hold = pay_valid && !pay_ready;
            if (pay_valid && pay_ready) sp++;

            @(posedge clk); #1;
            if (expect_done) begin
               tx_req = 1'b0;
            end else if (abort_at >= 0 && idx == 22 + abort_at) begin
               tx_abort = 1'b1; abort_now = 1; tx_req = 1'b0;
            end else if (rst_at >= 0 && idx == rst_at) begin
               rst_n = 1'b0; rst_now = 1; tx_req = 1'b0;
            end else begin
               tx_req    = 1'($urandom_range(1));
               tx_rate   = 4'($urandom_range(15));
               tx_length = 12'($urandom_range(4095));
            end
            sym_ready = (stall == 0) ? 1'b1 : ($urandom_range(99) >= stall);
            pay_valid = pv_hold ? 1'b1 :
                        ((stall == 0) ? 1'b1 : ($urandom_range(99) >= stall));
            pay_data  = (sp < src_q.size()) ? 4'(src_q[sp]) : 4'h0;
         end
      end
      check("frame_finished", finished, 1);
   endtask

   task automatic bad_req(input logic [3:0] rate, input logic [11:0] len);
      @(posedge clk); #1;
      tx_req = 1'b1; tx_rate = rate; tx_length = len;
      @(negedge clk);
      check("err_not_yet", tx_err, 0);
      @(posedge clk); #1;
      tx_req = 1'b0;
      @(negedge clk);
      check("tx_err", tx_err, 1);
      check("bad_no_ack", tx_ack, 0);
      check("bad_valid", sym_valid, 0);
      check("bad_busy", tx_busy, 0);
      @(negedge clk);
      check("err_pulse", tx_err, 0);
      check("bad_no_ack2", tx_ack, 0);
      check("bad_valid2", sym_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_frame(4'hD, 1, 0, -1, -1);
      run_frame(4'hB, 255, 0, -1, -1);
      repeat (4) run_frame(4'($urandom_range(7) * 2 + 1), int'($urandom_range(60, 1)), 35, -1, -1);
      bad_req(4'h5, 12'd0);
      bad_req(4'h4, 12'd5);
      run_frame(4'h7, 40, 25, 17, -1);
      run_frame(4'h3, 5, 20, -1, -1);
      run_frame(4'h9, 20, 0, -1, 14);
      run_frame(4'h1, 3, 30, -1, -1);
      run_frame(4'hF, 4095, 0, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tx_frame_sequencer.md
TX_FRAME_SEQUENCER -- requirements
Module: tx_frame_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port tx_req, input, 1 bit: PHY transmit request, sampled only in IDLE.
REQ-004 SHALL have port tx_rate, input, 4 bits: SIGNAL rate code, latched on acceptance.
REQ-005 SHALL have port tx_length, input, 12 bits: payload octet count, legal 1-4095, latched on acceptance.
REQ-006 SHALL have port tx_abort, input, 1 bit: abort the frame in progress.
REQ-007 SHALL have port pay_data, input, 4 bits: payload nibble from the data source, low nibble of each octet first.
REQ-008 SHALL have port pay_valid, input, 1 bit: pay_data valid.
REQ-009 SHALL have port pay_ready, output, 1 bit: payload nibble consumed.
REQ-010 SHALL have port sym_data, output, 4 bits: nibble to the TX chain.
REQ-011 SHALL have port sym_valid, output, 1 bit: sym_data valid.
REQ-012 SHALL have port sym_ready, input, 1 bit: TX chain accepts the nibble.
REQ-013 SHALL have port sym_phase, output, 2 bits: 0 = preamble, 1 = signal, 2 = data, 3 = idle.
REQ-014 SHALL have port scr_init, output, 1 bit: one-cycle pulse to reseed the scrambler.
REQ-015 SHALL have port scr_en, output, 1 bit: current nibble is to be scrambled.
REQ-016 SHALL have ports tx_busy, tx_ack, tx_err and tx_done, outputs, 1 bit each: busy level, accept pulse, reject pulse, completion pulse.

Function
REQ-017 SHALL implement the states IDLE, PREAMBLE, SIGNAL, SERVICE, PAYLOAD and TAIL; a nibble transfers only on a cycle with sym_valid and sym_ready both high.
REQ-018 SHALL, in IDLE with tx_req=1, accept the request when tx_length!=0 and tx_rate[0]=1 (the legal codes are 1,3,5,7,9,B,D,F), entering PREAMBLE on the next cycle.
REQ-019 SHALL, for an illegal request, pulse tx_err one cycle after tx_req, latch nothing and remain in IDLE.
REQ-020 SHALL pulse tx_ack during the first PREAMBLE cycle; tx_busy SHALL be 1 in every state except IDLE.
REQ-021 SHALL, in PREAMBLE, emit the 12 nibbles 1,D,5,B,3,E,6,8,0,0,0,0 in that order with sym_phase=0.
REQ-022 SHALL build the 24-bit SIGNAL word S as: S[3:0]=rate, S[4]=0, S[16:5]=length, S[17]=XOR of S[16:0] (even parity), S[23:18]=0.
REQ-023 SHALL, in SIGNAL, emit nibble k = S[4k+3:4k] for k=0..5 with sym_phase=1 and scr_en=0.
REQ-024 SHALL pulse scr_init for one cycle in the first SERVICE cycle.
REQ-025 SHALL, in SERVICE, emit 4 zero nibbles with scr_en=1.
REQ-026 SHALL, in PAYLOAD, drive sym_data=pay_data, sym_valid=pay_valid and pay_ready=sym_ready, with scr_en=1, until exactly 2*length nibbles have transferred.
REQ-027 SHALL hold pay_ready=0 in every state other than PAYLOAD.
REQ-028 SHALL, in TAIL, emit 2 zero nibbles (6 tail bits plus 2 pad bits) with scr_en=0.
REQ-029 SHALL drive sym_phase=2 in SERVICE, PAYLOAD and TAIL.
REQ-030 SHALL pulse tx_done on the cycle after the last TAIL transfer and return to IDLE on that same cycle; the total frame SHALL be 24+2*length nibbles.
REQ-031 SHALL keep sym_valid=1 in every non-IDLE state except PAYLOAD.
REQ-032 SHALL hold sym_data stable while sym_valid=1 and sym_ready=0.
REQ-033 SHALL, when tx_abort=1 in any non-IDLE state, return to IDLE on the next cycle with no tx_done; tx_abort SHALL take priority over a simultaneous transfer.
REQ-034 SHALL ignore tx_req outside IDLE; a tx_req on the tx_done cycle SHALL be sampled in IDLE on the following cycle.
REQ-035 SHALL use a payload counter at least 13 bits wide, with no wrap at length=4095 (8190 nibbles).

Reset
REQ-036 SHALL, with rst_n=0 at a clock edge, force state IDLE and clear all counters and latched fields, regardless of the frame in progress.
REQ-037 SHALL, during reset, drive sym_valid, pay_ready, scr_init, scr_en, tx_busy, tx_ack, tx_err and tx_done to 0, sym_data to 0 and sym_phase to 3.

Verification
REQ-038 SHALL cover a request with rate=D, length=1 and sym_ready tied to 1 -> preamble nibbles as in REQ-021, then SIGNAL nibbles D,2,0,0,0,0, then 0,0,0,0, 2 payload nibbles, 0,0; 26 transfers in total, then tx_done.
REQ-039 SHALL cover a request with rate=B, length=0x0FF -> parity=1, SIGNAL nibbles B,E,F,1,2,0, and 510 payload transfers.
REQ-040 SHALL cover random sym_ready and pay_valid stalls -> no nibble lost or duplicated, and sym_data stable across every stall.
REQ-041 SHALL cover tx_length=0, and separately tx_rate=4 -> tx_err pulse, no tx_ack, sym_valid stays 0.
REQ-042 SHALL cover tx_abort asserted mid-PAYLOAD -> IDLE next cycle, no tx_done, and a new request then accepted normally.
REQ-043 SHALL cover rst_n=0 during SIGNAL -> all outputs at their REQ-037 values after one edge, and the next frame starting from preamble nibble 1.
